// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - angle constants, FSM state type and modulo phase add for the CORDIC NCO sequencer
package cordic_pkg;

  // Q16.16 radian constants
  localparam logic [31:0] TWO_PI        = 32'h0006_487F;
  localparam logic [31:0] PI            = 32'h0003_243F;
  localparam logic [31:0] HALF_PI       = 32'h0001_921F;
  localparam logic [31:0] THREE_HALF_PI = 32'h0004_B65F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // 33-bit add so the carry is never lost, then a single conditional wrap.
  // Both operands are below TWO_PI, so one subtraction is always enough.
  function automatic logic [31:0] phase_wrap_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, TWO_PI}) begin
      s = s - {1'b0, TWO_PI};
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/cordic_phase_acc.sv
// rtl/cordic_phase_acc.sv - phase accumulator with modulo-2pi step and quadrant fold to CORDIC range
module cordic_phase_acc
  import cordic_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_phase0,
  input  logic        i_step,
  input  logic [31:0] i_fcw,
  output logic [31:0] o_phase,
  output logic [31:0] o_theta,
  output logic        o_neg
);

  logic [31:0] r_phase;
  logic [31:0] w_theta;
  logic        w_neg;

  // Phase register: load has priority over a step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= 32'd0;
    end else if (i_load) begin
      r_phase <= i_phase0;
    end else if (i_step) begin
      r_phase <= phase_wrap_add(r_phase, i_fcw);
    end
  end

  // Fold the phase into [-pi/2, pi/2]; the middle half-turn is rotated by pi
  // and flagged so the result can be negated afterwards
  always_comb begin
    w_theta = r_phase;
    w_neg   = 1'b0;
    if (r_phase >= THREE_HALF_PI) begin
      w_theta = r_phase - TWO_PI;
    end else if (r_phase > HALF_PI) begin
      w_theta = r_phase - PI;
      w_neg   = 1'b1;
    end
  end

  assign o_phase = r_phase;
  assign o_theta = w_theta;
  assign o_neg   = w_neg;

endmodule

// File: rtl/cordic_nco_seq.sv
// rtl/cordic_nco_seq.sv - sequencer driving an external CORDIC to produce quadrant-corrected sin/cos samples
module cordic_nco_seq
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [31:0]      i_phase0,
  input  logic [31:0]      i_fcw,
  output logic             o_cordic_en,
  output logic [31:0]      o_cordic_theta,
  input  logic             i_cordic_vld,
  input  logic [WIDTH:0]   i_cordic_cos,
  input  logic [WIDTH:0]   i_cordic_sin,
  output logic [WIDTH:0]   o_cos,
  output logic [WIDTH:0]   o_sin,
  output logic             o_vld,
  output logic             o_busy,
  output logic             o_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;
  logic           r_en;
  logic [31:0]    r_theta;
  logic [WIDTH:0] r_cos;
  logic [WIDTH:0] r_sin;
  logic           r_vld;
  logic           r_busy;
  logic           r_err;

  logic [31:0]    w_phase;
  logic [31:0]    w_theta;
  logic           w_neg;
  logic           w_load;
  logic           w_step;
  logic           w_range_err;

  // Negation where the most-negative code has no positive twin, so clamp it
  function automatic logic [WIDTH:0] neg_sat(input logic [WIDTH:0] v);
    if (v == {1'b1, {WIDTH{1'b0}}}) begin
      return {1'b0, {WIDTH{1'b1}}};
    end
    return -v;
  endfunction

  assign w_load      = (r_state == IDLE) && i_load;
  assign w_range_err = (i_fcw >= TWO_PI) || (w_phase >= TWO_PI);
  assign w_step      = (r_state == ISSUE) && !w_range_err;

  cordic_phase_acc u_phase_acc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .i_phase0 (i_phase0),
    .i_step   (w_step),
    .i_fcw    (i_fcw),
    .o_phase  (w_phase),
    .o_theta  (w_theta),
    .o_neg    (w_neg)
  );

  // Sequencer FSM with all outputs registered; a sticky error parks it in IDLE until reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_en    <= 1'b0;
      r_theta <= 32'd0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en  <= 1'b0;
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_load && i_run && !r_err) begin
            r_state <= ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_range_err) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_en    <= 1'b1;
            r_theta <= w_theta;
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_cordic_vld) begin
            r_cos   <= r_neg ? neg_sat(i_cordic_cos) : i_cordic_cos;
            r_sin   <= r_neg ? neg_sat(i_cordic_sin) : i_cordic_sin;
            r_state <= OUT;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        OUT: begin
          r_vld <= 1'b1;
          if (i_run) begin
            r_state <= ISSUE;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cordic_en    = r_en;
  assign o_cordic_theta = r_theta;
  assign o_cos          = r_cos;
  assign o_sin          = r_sin;
  assign o_vld          = r_vld;
  assign o_busy         = r_busy;
  assign o_err          = r_err;

endmodule

// File: tb/tb_cordic_nco_seq.sv
// tb/tb_cordic_nco_seq.sv - directed self-checking bench for cordic_nco_seq with a latency-programmable CORDIC model
module tb_cordic_nco_seq;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_run;
  logic        i_load;
  logic [31:0] i_phase0;
  logic [31:0] i_fcw;
  logic        o_cordic_en;
  logic [31:0] o_cordic_theta;
  logic        i_cordic_vld;
  logic [16:0] o_cos;
  logic [16:0] o_sin;
  logic        o_vld;
  logic        o_busy;
  logic        o_err;

  logic               m_vld = 1'b0;
  logic               f_vld = 1'b0;
  logic               m_on = 1'b0;
  int                 m_lat = 1;
  logic               m_pend = 1'b0;
  int                 m_cnt = 0;
  logic signed [16:0] m_cos = '0;
  logic signed [16:0] m_sin = '0;

  int                 cyc = 0;
  int                 en_count = 0;
  logic [31:0]        m_theta [0:63];
  int                 en_cyc  [0:63];
  logic signed [16:0] s_cos   [0:7];
  logic signed [16:0] s_sin   [0:7];

  int n_checks = 0;
  int n_pass   = 0;

  assign i_cordic_vld = m_vld | f_vld;

  cordic_nco_seq #(.WIDTH(16), .TIMEOUT(64)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_run          (i_run),
    .i_load         (i_load),
    .i_phase0       (i_phase0),
    .i_fcw          (i_fcw),
    .o_cordic_en    (o_cordic_en),
    .o_cordic_theta (o_cordic_theta),
    .i_cordic_vld   (i_cordic_vld),
    .i_cordic_cos   (m_cos),
    .i_cordic_sin   (m_sin),
    .o_cos          (o_cos),
    .o_sin          (o_sin),
    .o_vld          (o_vld),
    .o_busy         (o_busy),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CORDIC model: answers m_lat cycles after it sees the strobe, logs every strobe
  always @(negedge clk) begin
    m_vld = 1'b0;
    if (m_pend) begin
      if (m_cnt == 0) begin
        m_vld  = 1'b1;
        m_pend = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (o_cordic_en) begin
      if (en_count < 64) begin
        m_theta[en_count] = o_cordic_theta;
        en_cyc[en_count]  = cyc;
      end
      en_count = en_count + 1;
      if (m_on) begin
        if (m_lat == 0) m_vld = 1'b1;
        else begin
          m_pend = 1'b1;
          m_cnt  = m_lat - 1;
        end
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1; i_run = 1'b0; i_load = 1'b0; f_vld = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic run_seq(input logic [31:0] p0, input logic [31:0] fcw, input int n,
                         input bit together, input bit hold_load,
                         output int got, output int base, output int run_cyc);
    base = en_count;
    got  = 0;
    @(negedge clk);
    i_phase0 = p0; i_fcw = fcw; i_load = 1'b1;
    if (together) i_run = 1'b1;
    @(negedge clk);
    i_load  = 1'b0;
    run_cyc = cyc;
    i_run   = 1'b1;
    for (int t = 0; t < 300 && got < n; t++) begin
      @(negedge clk);
      if (en_count - base >= n) i_run = 1'b0;
      if (hold_load && (en_count - base >= 1)) begin
        i_load = 1'b1; i_phase0 = 32'h0003_0000;
      end
      if (o_vld) begin
        if (got < 8) begin s_cos[got] = o_cos; s_sin[got] = o_sin; end
        got++;
      end
    end
    i_run = 1'b0; i_load = 1'b0;
    for (int t = 0; t < 20 && o_busy; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    i_phase0 = 32'd0; i_fcw = 32'd0;
    do_reset();
    @(negedge clk);
    n_checks++; if (o_cos !== 17'd0) $display("FAIL reset_cos got=%0d exp=0", o_cos); else n_pass++;
    n_checks++; if (o_sin !== 17'd0) $display("FAIL reset_sin got=%0d exp=0", o_sin); else n_pass++;
    n_checks++; if (o_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", o_vld); else n_pass++;
    n_checks++; if (o_cordic_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", o_cordic_en); else n_pass++;
    n_checks++; if (o_cordic_theta !== 32'd0) $display("FAIL reset_theta got=%h exp=0", o_cordic_theta); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", o_err); else n_pass++;
  endtask

  task automatic test_zero_phase();
    int got, b, rc;
    do_reset();
    m_on = 1'b1; m_lat = 1; m_cos = 17'sd65535; m_sin = 17'sd0;
    run_seq(32'd0, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (got !== 1) $display("FAIL zero_count got=%0d exp=1", got); else n_pass++;
    n_checks++; if (s_cos[0] !== 17'sd65535) $display("FAIL zero_cos got=%0d exp=65535", s_cos[0]); else n_pass++;
    n_checks++; if (s_sin[0] !== 17'sd0) $display("FAIL zero_sin got=%0d exp=0", s_sin[0]); else n_pass++;
    n_checks++; if (m_theta[b] !== 32'd0) $display("FAIL zero_theta got=%h exp=0", m_theta[b]); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL zero_err got=%b exp=0", o_err); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL zero_idle_busy got=%b exp=0", o_busy); else n_pass++;
  endtask

  task automatic test_pi_negate();
    int got, b, rc;
    do_reset();
    m_on = 1'b1; m_lat = 1; m_cos = 17'sd65535; m_sin = 17'sd0;
    run_seq(32'h0003_243F, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (got !== 1) $display("FAIL pi_count got=%0d exp=1", got); else n_pass++;
    n_checks++; if (m_theta[b] !== 32'd0) $display("FAIL pi_theta got=%h exp=0", m_theta[b]); else n_pass++;
    n_checks++; if (s_cos[0] !== -17'sd65535) $display("FAIL pi_cos got=%0d exp=-65535", s_cos[0]); else n_pass++;
    n_checks++; if (s_sin[0] !== 17'sd0) $display("FAIL pi_sin got=%0d exp=0", s_sin[0]); else n_pass++;
  endtask

  task automatic test_fold();
    int got, b, rc;
    do_reset();
    m_on = 1'b1; m_lat = 1; m_cos = 17'sd100; m_sin = -17'sd200;
    run_seq(32'h0006_4000, 32'h0000_1000, 2, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (got !== 2) $display("FAIL fold_count got=%0d exp=2", got); else n_pass++;
    n_checks++; if (m_theta[b] !== 32'hFFFF_F781) $display("FAIL fold_theta0 got=%h exp=fffff781", m_theta[b]); else n_pass++;
    n_checks++; if (m_theta[b+1] !== 32'h0000_0781) $display("FAIL fold_theta1 got=%h exp=00000781", m_theta[b+1]); else n_pass++;
    n_checks++; if (s_cos[1] !== 17'sd100) $display("FAIL fold_cos1 got=%0d exp=100", s_cos[1]); else n_pass++;
    n_checks++; if (s_sin[1] !== -17'sd200) $display("FAIL fold_sin1 got=%0d exp=-200", s_sin[1]); else n_pass++;
    run_seq(32'h0004_B65F, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (m_theta[b] !== 32'hFFFE_6DE0) $display("FAIL fold_3half_theta got=%h exp=fffe6de0", m_theta[b]); else n_pass++;
    n_checks++; if (s_cos[0] !== 17'sd100) $display("FAIL fold_3half_cos got=%0d exp=100", s_cos[0]); else n_pass++;
    run_seq(32'h0004_B65E, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (m_theta[b] !== 32'h0001_921F) $display("FAIL fold_below3half_theta got=%h exp=0001921f", m_theta[b]); else n_pass++;
    n_checks++; if (s_cos[0] !== -17'sd100) $display("FAIL fold_below3half_cos got=%0d exp=-100", s_cos[0]); else n_pass++;
    run_seq(32'h0001_921F, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (m_theta[b] !== 32'h0001_921F) $display("FAIL fold_half_theta got=%h exp=0001921f", m_theta[b]); else n_pass++;
    n_checks++; if (s_cos[0] !== 17'sd100) $display("FAIL fold_half_cos got=%0d exp=100", s_cos[0]); else n_pass++;
    run_seq(32'h0001_9220, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (m_theta[b] !== 32'hFFFE_6DE1) $display("FAIL fold_abovehalf_theta got=%h exp=fffe6de1", m_theta[b]); else n_pass++;
    n_checks++; if (s_sin[0] !== 17'sd200) $display("FAIL fold_abovehalf_sin got=%0d exp=200", s_sin[0]); else n_pass++;
  endtask

  task automatic test_saturate();
    int got, b, rc;
    do_reset();
    m_on = 1'b1; m_lat = 1; m_cos = -17'sd65536; m_sin = 17'sd5;
    run_seq(32'h0003_243F, 32'd0, 1, 1'b0, 1'b0, got, b, rc);
    n_checks++; if (s_cos[0] !== 17'sd65535) $display("FAIL sat_cos got=%0d exp=65535", s_cos[0]); else n_pass++;
    n_checks++; if (s_sin[0] !== -17'sd5) $display("FAIL sat_sin got=%0d exp=-5", s_sin[0]); else n_pass++;
  endtask

  task automatic test_bad_range();
    int b;
    logic saw_vld;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      m_on = 1'b1; m_lat = 1;
      b = en_count;
      saw_vld = 1'b0;
      @(negedge clk);
      i_phase0 = (k == 0) ? 32'd0 : 32'h0006_487F;
      i_fcw    = (k == 0) ? 32'h0006_487F : 32'd0;
      i_load   = 1'b1;
      @(negedge clk);
      i_load = 1'b0; i_run = 1'b1;
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        if (o_vld) saw_vld = 1'b1;
      end
      n_checks++; if (en_count - b !== 0) $display("FAIL bad%0d_strobes got=%0d exp=0", k, en_count - b); else n_pass++;
      n_checks++; if (o_err !== 1'b1) $display("FAIL bad%0d_err got=%b exp=1", k, o_err); else n_pass++;
      n_checks++; if (o_busy !== 1'b0) $display("FAIL bad%0d_busy got=%b exp=0", k, o_busy); else n_pass++;
      n_checks++; if (saw_vld !== 1'b0) $display("FAIL bad%0d_vld got=%b exp=0", k, saw_vld); else n_pass++;
      i_run = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int b, k;
    logic seen;
    do_reset();
    m_on = 1'b0;
    b = en_count;
    @(negedge clk);
    i_phase0 = 32'd0; i_fcw = 32'd0; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0; i_run = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (o_cordic_en) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL timeout_strobe got=%b exp=1", seen); else n_pass++;
    k = 0;
    for (int t = 0; t < 100 && !o_err; t++) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k !== 64) $display("FAIL timeout_cycles got=%0d exp=64", k); else n_pass++;
    n_checks++; if (o_err !== 1'b1) $display("FAIL timeout_err got=%b exp=1", o_err); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL timeout_busy got=%b exp=0", o_busy); else n_pass++;
    n_checks++; if (en_count - b !== 1) $display("FAIL timeout_no_reissue got=%0d exp=1", en_count - b); else n_pass++;
    i_run = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic seen, saw_vld;
    do_reset();
    m_on = 1'b0; m_cos = 17'sd123; m_sin = 17'sd77;
    @(negedge clk);
    i_phase0 = 32'h0001_0000; i_fcw = 32'd0; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0; i_run = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (o_cordic_en) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL rstwait_strobe got=%b exp=1", seen); else n_pass++;
    repeat (3) @(negedge clk);
    i_rst = 1'b1; i_run = 1'b0;
    @(negedge clk);
    i_rst = 1'b0; f_vld = 1'b1;
    saw_vld = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t == 1) f_vld = 1'b0;
      if (o_vld) saw_vld = 1'b1;
    end
    n_checks++; if (saw_vld !== 1'b0) $display("FAIL rstwait_vld got=%b exp=0", saw_vld); else n_pass++;
    n_checks++; if (o_cos !== 17'd0) $display("FAIL rstwait_cos got=%0d exp=0", o_cos); else n_pass++;
    n_checks++; if (o_sin !== 17'd0) $display("FAIL rstwait_sin got=%0d exp=0", o_sin); else n_pass++;
    n_checks++; if (o_cordic_theta !== 32'd0) $display("FAIL rstwait_theta got=%h exp=0", o_cordic_theta); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rstwait_busy got=%b exp=0", o_busy); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL rstwait_err got=%b exp=0", o_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got, b, rc;
    do_reset();
    m_on = 1'b1; m_lat = 2; m_cos = 17'sd1000; m_sin = 17'sd2000;
    run_seq(32'd0, 32'h0000_1000, 3, 1'b0, 1'b1, got, b, rc);
    n_checks++; if (got !== 3) $display("FAIL b2b_count got=%0d exp=3", got); else n_pass++;
    n_checks++; if (en_cyc[b] - rc !== 2) $display("FAIL b2b_first_delay got=%0d exp=2", en_cyc[b] - rc); else n_pass++;
    n_checks++; if (en_cyc[b+1] - en_cyc[b] !== 5) $display("FAIL b2b_period0 got=%0d exp=5", en_cyc[b+1] - en_cyc[b]); else n_pass++;
    n_checks++; if (en_cyc[b+2] - en_cyc[b+1] !== 5) $display("FAIL b2b_period1 got=%0d exp=5", en_cyc[b+2] - en_cyc[b+1]); else n_pass++;
    n_checks++; if (m_theta[b+1] !== 32'h0000_1000) $display("FAIL b2b_theta1 got=%h exp=00001000", m_theta[b+1]); else n_pass++;
    n_checks++; if (m_theta[b+2] !== 32'h0000_2000) $display("FAIL b2b_theta2 got=%h exp=00002000", m_theta[b+2]); else n_pass++;
    n_checks++; if (s_sin[2] !== 17'sd2000) $display("FAIL b2b_sin2 got=%0d exp=2000", s_sin[2]); else n_pass++;
  endtask

  task automatic test_load_with_run();
    int got, b, rc;
    do_reset();
    m_on = 1'b1; m_lat = 1; m_cos = 17'sd7; m_sin = 17'sd1234;
    run_seq(32'h0003_243F, 32'd0, 1, 1'b1, 1'b0, got, b, rc);
    n_checks++; if (got !== 1) $display("FAIL loadrun_count got=%0d exp=1", got); else n_pass++;
    n_checks++; if (m_theta[b] !== 32'd0) $display("FAIL loadrun_theta got=%h exp=0", m_theta[b]); else n_pass++;
    n_checks++; if (s_cos[0] !== -17'sd7) $display("FAIL loadrun_cos got=%0d exp=-7", s_cos[0]); else n_pass++;
    n_checks++; if (s_sin[0] !== -17'sd1234) $display("FAIL loadrun_sin got=%0d exp=-1234", s_sin[0]); else n_pass++;
  endtask

  initial begin
    i_rst = 1'b1; i_run = 1'b0; i_load = 1'b0; i_phase0 = 32'd0; i_fcw = 32'd0;
    test_reset();
    test_zero_phase();
    test_pi_negate();
    test_fold();
    test_saturate();
    test_bad_range();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_load_with_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_nco_seq.md
CORDIC_NCO_SEQ -- requirements
Module: cordic_nco_seq

Interface
REQ-001 Parameter WIDTH, default 16, CORDIC output magnitude width (samples are WIDTH+1 bits signed).
REQ-002 Parameter TIMEOUT, default 64, maximum cycles spent waiting for a CORDIC result.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_run  in  1  level; high = generate samples continuously.
REQ-006 i_load  in  1  pulse; load phase accumulator from i_phase0 (honoured in IDLE only).
REQ-007 i_phase0  in  32  unsigned Q16.16 radians, start phase, valid range [0, TWO_PI).
REQ-008 i_fcw  in  32  unsigned Q16.16 radians, per-sample phase increment, valid range [0, TWO_PI).
REQ-009 o_cordic_en  out  1  one-cycle request strobe to CORDIC.
REQ-010 o_cordic_theta  out  32  signed Q16.16 folded angle, valid while o_cordic_en high.
REQ-011 i_cordic_vld / i_cordic_cos / i_cordic_sin  in  1 / WIDTH+1 / WIDTH+1  CORDIC result, signed.
REQ-012 o_cos / o_sin  out  WIDTH+1 each  quadrant-corrected signed samples.
REQ-013 o_vld  out  1  one-cycle strobe, o_cos/o_sin valid.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_err  out  1  sticky error flag.

Function
REQ-016 Constants: TWO_PI=0x6487F, PI=0x3243F, HALF_PI=0x1921F, THREE_HALF_PI=0x4B65F.
REQ-017 FSM states IDLE, ISSUE, WAIT, OUT; all outputs registered.
REQ-018 IDLE: i_load high -> phase <= i_phase0; else if i_run high -> ISSUE next cycle; i_load and i_run together -> load wins this cycle, ISSUE follows when i_run still high.
REQ-019 On entering ISSUE, i_fcw ≥ TWO_PI or phase ≥ TWO_PI -> set o_err, return to IDLE, no strobe.
REQ-020 ISSUE: o_cordic_en=1 for exactly one cycle with folded theta; negate flag latched; phase <= (phase+i_fcw) computed 33-bit, minus TWO_PI when sum ≥ TWO_PI; -> WAIT.
REQ-021 Fold: phase ≤ HALF_PI -> theta=phase, neg=0; HALF_PI < phase < THREE_HALF_PI -> theta=phase-PI, neg=1; phase ≥ THREE_HALF_PI -> theta=phase-TWO_PI, neg=0.
REQ-022 WAIT: cycle counter starts at 0; i_cordic_vld high -> capture result, -> OUT; counter reaching TIMEOUT-1 without vld -> o_err=1, -> IDLE.
REQ-023 Capture: neg=0 -> pass through; neg=1 -> two's-complement negate, most-negative value saturates to +(2^WIDTH-1).
REQ-024 OUT: o_vld=1 one cycle; -> ISSUE if i_run high, else IDLE.
REQ-025 i_run deassert mid-sample: current sample completes and is output, then IDLE.
REQ-026 i_cordic_vld outside WAIT ignored; i_load outside IDLE ignored.
REQ-027 Throughput: one sample per (3 + CORDIC latency) cycles; i_run high -> first o_cordic_en 2 cycles after i_run sampled.

Reset
REQ-028 i_rst high -> state IDLE, phase=0, counter=0, neg=0, all outputs 0 (o_err cleared) on next edge.
REQ-029 Reset mid-WAIT abandons the sample; a late i_cordic_vld after reset produces no o_vld.

Structure
REQ-030 Package cordic_pkg holds angle constants of REQ-016 and the FSM state enum.
REQ-031 One sub-module cordic_phase_acc: registered phase, modulo add, fold to theta/neg.

Verification
REQ-032 phase0=0, fcw=0, run; model returns cos=65535, sin=0 -> o_cos=65535, o_sin=0, theta=0.
REQ-033 phase0=0x3243F; model returns 65535,0 -> theta=0, o_cos=-65535, o_sin=0.
REQ-034 phase0=0x64000, fcw=0x1000 -> second sample theta=0x781; phase0=0x4B65F -> theta=-0x19220, neg=0.
REQ-035 Model never asserts vld -> o_err=1 after 64 WAIT cycles, o_busy=0, no further o_cordic_en.
REQ-036 phase0=PI, model cos=-65536 -> o_cos=65535; fcw=0x6487F -> o_err=1, no strobe.
REQ-037 i_rst during WAIT, then late vld -> o_vld stays 0, all outputs 0.
